// File: rtl/booth_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_sched_pkg
// Description : Shared widths, iteration count and FSM encoding for booth_sched.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_sched_pkg;

    localparam int C_MUL_W    = 8;
    localparam int C_MUL_ITER = 8;
    localparam int C_PROD_W   = 2 * C_MUL_W;
    localparam int C_CNT_W    = $clog2(C_MUL_ITER);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_MUL_ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_CAPT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/booth.sv
`default_nettype none
// ============================================================================
// Module      : booth
// Description : Radix-2 sequential Booth multiplier, 8x8 signed, one step/clock.
// Revision    : 1.0 - initial release
// ============================================================================
module booth
    import booth_sched_pkg::*;
(
    input  logic                clk,
    input  logic                start,
    input  logic [C_MUL_W-1:0]  X,
    input  logic [C_MUL_W-1:0]  Y,
    output logic [C_PROD_W-1:0] produs
);

    logic [C_MUL_W-1:0] r_a;
    logic [C_MUL_W-1:0] r_q;
    logic [C_MUL_W-1:0] r_m;
    logic               r_q1;
    logic [C_MUL_W-1:0] w_sum;

    always_comb begin
        case ({r_q[0], r_q1})
            2'b01:   w_sum = r_a + r_m;
            2'b10:   w_sum = r_a - r_m;
            default: w_sum = r_a;
        endcase
    end

    // No reset: start reloads the whole datapath before any product is used.
    always_ff @(posedge clk) begin
        if (start) begin
            r_a  <= '0;
            r_q  <= X;
            r_q1 <= 1'b0;
            r_m  <= Y;
        end else begin
            {r_a, r_q, r_q1} <= {w_sum[C_MUL_W-1], w_sum, r_q};
        end
    end

    assign produs = {r_a, r_q};

endmodule
`default_nettype wire

// File: rtl/booth_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : booth_rr_pick
// Description : Combinational round-robin picker, searches from last+1 upward.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_rr_pick #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_last,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_idx,
    output logic             o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = i_last;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = (w_cand == ID_W'(N_REQ - 1)) ? '0 : w_cand + ID_W'(1);
            if (!o_any && i_valid[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/booth_sched.sv
`default_nettype none
// ============================================================================
// Module      : booth_sched
// Description : Round-robin sharing of one Booth multiplier among N_REQ clients.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_sched
    import booth_sched_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [C_MUL_W*N_REQ-1:0]   req_x,
    input  logic [C_MUL_W*N_REQ-1:0]   req_y,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [C_PROD_W-1:0]        rsp_produs
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_MUL_W-1:0]  r_x;
    logic [C_MUL_W-1:0]  r_y;
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [C_PROD_W-1:0] r_rsp_produs;

    logic [N_REQ-1:0]    w_grant;
    logic [ID_W-1:0]     w_idx;
    logic                w_any;
    logic                w_start;
    logic [C_MUL_W-1:0]  w_bx;
    logic [C_MUL_W-1:0]  w_by;
    logic [C_PROD_W-1:0] w_produs;
    logic [C_MUL_W-1:0]  w_x_arr [N_REQ];
    logic [C_MUL_W-1:0]  w_y_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_x_arr[gi] = req_x[C_MUL_W*gi +: C_MUL_W];
            assign w_y_arr[gi] = req_y[C_MUL_W*gi +: C_MUL_W];
        end
    endgenerate

    booth_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_valid (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    booth u_booth (
        .clk    (clk),
        .start  (w_start),
        .X      (w_bx),
        .Y      (w_by),
        .produs (w_produs)
    );

    // The multiplier iterates only in RUN; everywhere else it is held reloading.
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        w_start     = 1'b1;
        w_bx        = r_x;
        w_by        = r_y;
        case (r_state)
            ST_IDLE: begin
                w_bx = w_x_arr[w_idx];
                w_by = w_y_arr[w_idx];
                if (w_any) begin
                    req_ready   = w_grant;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_start = 1'b0;
                if (r_cnt == C_CNT_LAST) w_state_nxt = ST_CAPT;
            end
            ST_CAPT: w_state_nxt = ST_DONE;
            ST_DONE: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last       <= ID_W'(N_REQ - 1);
            r_id         <= '0;
            r_cnt        <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_produs <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id   <= w_idx;
                        r_last <= w_idx;
                        r_cnt  <= '0;
                        r_x    <= w_bx;
                        r_y    <= w_by;
                    end
                end
                ST_RUN:  r_cnt <= r_cnt + C_CNT_W'(1);
                // Product is only valid this cycle; the multiplier reloads next edge.
                ST_CAPT: begin
                    r_rsp_produs <= w_produs;
                    r_rsp_id     <= r_id;
                    r_rsp_valid  <= 1'b1;
                end
                ST_DONE: if (rsp_ready) r_rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_produs = r_rsp_produs;

endmodule
`default_nettype wire
